list_stream_cache: RTL and testbench

- Parametrised successor to the single-mode list cache.
- Accepts wide fetch packets: one header word plus up to FS-1 payload words.
- Stores them in a ring of BS line buffers and streams the payload out one word per cycle behind a registered valid/ready output.
- Adds over the previous generation: true input handshake, variable-length lines, end-of-list marking, flush, and occupancy reporting. Sits between the list fetcher and element consumers.

---
 rtl/list_stream_cache_if.sv | 39 +++
 rtl/list_stream_cache.sv | 187 ++++++++++++++++++
 tb/tb_list_stream_cache.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/list_stream_cache_if.sv
// list_stream_cache_if: packet-in / element-out bus of list_stream_cache.
//
// Handshake rules for both directions: a transfer happens at a rising CLK
// edge where valid and ready are both 1. The producer of valid never waits
// for ready before raising valid, and once valid is high it keeps its data
// stable until the transfer happens. The ready side may change ready freely
// and ready never depends on valid in the same cycle.
//   input side : IN/in_valid from the fetcher, in_ready from the cache
//   output side: OUT/o_valid/o_last from the cache, i_ready from the consumer
// flush is a plain synchronous command from the fetcher side.
interface list_stream_cache_if #(
    parameter int DW = 32,
    parameter int FS = 8,
    parameter int BS = 2
);
    localparam int OW = $clog2(BS + 1);

    logic [FS*DW-1:0] IN;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [DW-1:0]    OUT;
    logic             o_valid;
    logic             o_last;
    logic             i_ready;
    logic [OW-1:0]    occupancy;

    // Fetcher/consumer side (drives packets, flush and the output ready)
    modport master (
        output IN, in_valid, flush, i_ready,
        input  in_ready, OUT, o_valid, o_last, occupancy
    );

    // Cache side
    modport slave (
        input  IN, in_valid, flush, i_ready,
        output in_ready, OUT, o_valid, o_last, occupancy
    );
endinterface

// File: rtl/list_stream_cache.sv
// list_stream_cache: ring of BS line buffers. Each accepted fetch packet
// (header + up to FS-1 payload words) fills one line; lines are streamed
// out one word per cycle through a registered valid/ready output stage.
// Header: bit0 sequence toggle, bits [CW:1] payload count, bit DW-1 end of
// list. Optional duplicate-drop on the toggle bit is enabled by defining
// LIST_STREAM_CACHE_DUP_DROP_EN.
module list_stream_cache #(
    parameter int DW = 32,
    parameter int FS = 8,
    parameter int BS = 2
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    list_stream_cache_if.slave   bus
);
    localparam int TS = FS - 1;
    localparam int CW = $clog2(TS + 1);
    localparam int OW = $clog2(BS + 1);
    localparam int PW = $clog2(BS);
    localparam logic [CW-1:0] TS_C = CW'(TS);
    localparam logic [OW-1:0] BS_C = OW'(BS);

    // Line storage (no reset needed: a line is only read while valid)
    logic [DW-1:0] line_data_q [BS][TS];
    logic [CW-1:0] line_cnt_q  [BS];
    logic [BS-1:0] line_end_q;

    logic [BS-1:0] line_vld_q, line_vld_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] rd_word_q, rd_word_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [DW-1:0] out_q, out_d;
    logic          o_valid_q, o_valid_d;
    logic          o_last_q, o_last_d;

    // Header decode
    logic [DW-1:0] hdr;
    logic [CW-1:0] hdr_cnt;
    logic [CW-1:0] cnt_clamp;
    logic          hdr_end;
    logic          unused_hdr;

    logic in_ready_w;
    logic accept;
    logic is_dup;
    logic alloc;

    // Read side
    logic          load;
    logic          rd_avail;
    logic [CW-1:0] rd_cnt;
    logic          rd_last_word;
    logic          free;

    assign hdr        = bus.IN[DW-1:0];
    assign hdr_cnt    = hdr[CW:1];
    assign hdr_end    = hdr[DW-1];
    assign cnt_clamp  = (int'(hdr_cnt) > TS) ? TS_C : hdr_cnt;
    assign unused_hdr = ^hdr;

    // Full is judged on the registered count only, so ready never looks at valid
    assign in_ready_w = (occ_q < BS_C);
    assign accept     = bus.in_valid & in_ready_w & ~bus.flush;

`ifdef LIST_STREAM_CACHE_DUP_DROP_EN
    logic last_tog_q, last_tog_d;
    assign is_dup = (hdr[0] == last_tog_q);
`else
    assign is_dup = 1'b0;
`endif

    // A zero-length or duplicate packet completes its handshake without a line
    assign alloc = accept & (cnt_clamp != '0) & ~is_dup;

    assign load         = ~o_valid_q | bus.i_ready;
    assign rd_avail     = line_vld_q[rd_ptr_q];
    assign rd_cnt       = line_cnt_q[rd_ptr_q];
    assign rd_last_word = (rd_word_q == (rd_cnt - CW'(1)));
    assign free         = ~bus.flush & load & rd_avail & rd_last_word;

    // Next-state: flush wins, otherwise output stage drain plus line allocation
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_word_d  = rd_word_q;
        line_vld_d = line_vld_q;
        occ_d      = occ_q;
        out_d      = out_q;
        o_valid_d  = o_valid_q;
        o_last_d   = o_last_q;
`ifdef LIST_STREAM_CACHE_DUP_DROP_EN
        last_tog_d = last_tog_q;
`endif
        if (bus.flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            rd_word_d  = '0;
            line_vld_d = '0;
            occ_d      = '0;
            o_valid_d  = 1'b0;
            o_last_d   = 1'b0;
        end else begin
            if (load) begin
                if (rd_avail) begin
                    out_d     = line_data_q[rd_ptr_q][rd_word_q];
                    o_valid_d = 1'b1;
                    o_last_d  = rd_last_word & line_end_q[rd_ptr_q];
                    if (rd_last_word) begin
                        rd_word_d            = '0;
                        rd_ptr_d             = rd_ptr_q + PW'(1);
                        line_vld_d[rd_ptr_q] = 1'b0;
                    end else begin
                        rd_word_d = rd_word_q + CW'(1);
                    end
                end else begin
                    o_valid_d = 1'b0;
                    o_last_d  = 1'b0;
                end
            end
            // wr_ptr line is always free when in_ready is high, so it never
            // collides with the line being freed in the same cycle
            if (alloc) begin
                line_vld_d[wr_ptr_q] = 1'b1;
                wr_ptr_d             = wr_ptr_q + PW'(1);
            end
            occ_d = occ_q + OW'(alloc) - OW'(free);
`ifdef LIST_STREAM_CACHE_DUP_DROP_EN
            if (accept && !is_dup) begin
                last_tog_d = hdr[0];
            end
`endif
        end
    end

    // Control and output registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_word_q  <= '0;
            line_vld_q <= '0;
            occ_q      <= '0;
            out_q      <= '0;
            o_valid_q  <= 1'b0;
            o_last_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_word_q  <= rd_word_d;
            line_vld_q <= line_vld_d;
            occ_q      <= occ_d;
            out_q      <= out_d;
            o_valid_q  <= o_valid_d;
            o_last_q   <= o_last_d;
        end
    end

`ifdef LIST_STREAM_CACHE_DUP_DROP_EN
    // Toggle of the last non-duplicate packet; survives flush, not reset
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            last_tog_q <= 1'b1;
        end else begin
            last_tog_q <= last_tog_d;
        end
    end
`endif

    // Line fill: payload word p lands in slot p-1; slots past cnt are don't-care
    always_ff @(posedge CLK) begin
        if (alloc) begin
            line_cnt_q[wr_ptr_q] <= cnt_clamp;
            line_end_q[wr_ptr_q] <= hdr_end;
            for (int s = 0; s < TS; s++) begin
                line_data_q[wr_ptr_q][s] <= bus.IN[(s+1)*DW +: DW];
            end
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.OUT       = out_q;
    assign bus.o_valid   = o_valid_q;
    assign bus.o_last    = o_last_q;
    assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_list_stream_cache.sv
// tb_list_stream_cache: directed bench for list_stream_cache (DW=32, FS=8,
// BS=2). Honours LIST_STREAM_CACHE_DUP_DROP_EN for the duplicate test.
module tb_list_stream_cache;
    localparam int DW = 32;
    localparam int FS = 8;
    localparam int BS = 2;
    localparam int CW = $clog2(FS);

    logic CLK = 1'b0;
    logic RESET_N;

    int vectors     = 0;
    int miscompares = 0;
    logic tb_tog;
    logic [DW:0] exp_q[$];

    list_stream_cache_if #(.DW(DW), .FS(FS), .BS(BS)) bus ();

    list_stream_cache #(.DW(DW), .FS(FS), .BS(BS)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packet: payload word p = base + p*0x11
    function automatic logic [FS*DW-1:0] mk_pkt(input logic tog, input int cnt,
                                                 input logic endf, input logic [DW-1:0] base);
        logic [FS*DW-1:0] p;
        p = '0;
        p[0]      = tog;
        p[CW:1]   = CW'(cnt);
        p[DW-1]   = endf;
        for (int w = 1; w < FS; w++) p[w*DW +: DW] = base + DW'(w * 'h11);
        return p;
    endfunction

    task automatic push_exp(input int cnt, input logic endf, input logic [DW-1:0] base);
        for (int p = 1; p <= cnt; p++)
            exp_q.push_back({(p == cnt) & endf, base + DW'(p * 'h11)});
    endtask

    // One clock: any element transferred at this edge is scoreboarded first
    task automatic tick();
        logic [DW:0] obs;
        logic [DW:0] exp;
        if (bus.o_valid && bus.i_ready) begin
            obs = {bus.o_last, bus.OUT};
            vectors++;
            assert (exp_q.size() > 0) else begin
                miscompares++;
                $error("FAIL unexpected_elem observed=%0h expected=none", obs);
            end
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                chk("elem", 64'(obs), 64'(exp));
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Present a packet until accepted (bounded), then drop in_valid
    task automatic send_pkt(input logic tog, input int cnt, input logic endf,
                            input logic [DW-1:0] base, input logic push);
        int n;
        bus.IN       = mk_pkt(tog, cnt, endf, base);
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", 64'(bus.in_ready), 64'(1));
        if (push) push_exp(cnt, endf, base);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'(0));
        chk("drain_ovalid", 64'(bus.o_valid), 64'(0));
        chk("drain_occ", 64'(bus.occupancy), 64'(0));
    endtask

    initial begin
        logic t;
        RESET_N      = 1'b0;
        bus.IN       = '0;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.i_ready  = 1'b0;
        tb_tog       = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_occ", 64'(bus.occupancy), 64'(0));
        chk("rst_ovalid", 64'(bus.o_valid), 64'(0));
        chk("rst_olast", 64'(bus.o_last), 64'(0));
        chk("rst_out", 64'(bus.OUT), 64'(0));
        chk("rst_inready", 64'(bus.in_ready), 64'(1));
        RESET_N = 1'b1;
        @(negedge CLK);

        // Single full line, latency and o_last placement
        tb_tog       = ~tb_tog;
        bus.IN       = mk_pkt(tb_tog, 7, 1'b1, 32'h0);
        bus.in_valid = 1'b1;
        bus.i_ready  = 1'b1;
        chk("t1_inready", 64'(bus.in_ready), 64'(1));
        push_exp(7, 1'b1, 32'h0);
        tick();
        bus.in_valid = 1'b0;
        chk("t1_occ_after_acc", 64'(bus.occupancy), 64'(1));
        chk("t1_ovalid_k", 64'(bus.o_valid), 64'(0));
        tick();
        chk("t1_first_out", 64'(bus.OUT), 64'h11);
        chk("t1_first_valid", 64'(bus.o_valid), 64'(1));
        chk("t1_first_last", 64'(bus.o_last), 64'(0));
        for (int i = 1; i <= 7; i++) begin
            chk("t1_stream_valid", 64'(bus.o_valid), 64'(1));
            chk("t1_stream_occ", 64'(bus.occupancy), (i == 7) ? 64'(0) : 64'(1));
            tick();
        end
        chk("t1_end_valid", 64'(bus.o_valid), 64'(0));
        chk("t1_queue", 64'(exp_q.size()), 64'(0));

        // Back-to-back lines, full stall of a third packet
        tb_tog       = ~tb_tog;
        bus.IN       = mk_pkt(tb_tog, 7, 1'b0, 32'h100);
        bus.in_valid = 1'b1;
        chk("t2_a_ready", 64'(bus.in_ready), 64'(1));
        push_exp(7, 1'b0, 32'h100);
        tick();
        tb_tog = ~tb_tog;
        bus.IN = mk_pkt(tb_tog, 7, 1'b1, 32'h200);
        chk("t2_b_ready", 64'(bus.in_ready), 64'(1));
        chk("t2_b_occ", 64'(bus.occupancy), 64'(1));
        push_exp(7, 1'b1, 32'h200);
        tick();
        tb_tog = ~tb_tog;
        bus.IN = mk_pkt(tb_tog, 7, 1'b1, 32'h300);
        chk("t2_full_occ", 64'(bus.occupancy), 64'(2));
        for (int i = 0; i < 6; i++) begin
            chk("t2_full_ready", 64'(bus.in_ready), 64'(0));
            chk("t2_full_valid", 64'(bus.o_valid), 64'(1));
            tick();
        end
        chk("t2_freed_ready", 64'(bus.in_ready), 64'(1));
        chk("t2_freed_occ", 64'(bus.occupancy), 64'(1));
        chk("t2_a7_out", 64'(bus.OUT), 64'h177);
        chk("t2_a7_last", 64'(bus.o_last), 64'(0));
        push_exp(7, 1'b1, 32'h300);
        tick();
        bus.in_valid = 1'b0;
        chk("t2_c_occ", 64'(bus.occupancy), 64'(2));
        for (int i = 0; i < 14; i++) begin
            chk("t2_nogap_valid", 64'(bus.o_valid), 64'(1));
            tick();
        end
        chk("t2_end_valid", 64'(bus.o_valid), 64'(0));
        chk("t2_queue", 64'(exp_q.size()), 64'(0));
        chk("t2_end_occ", 64'(bus.occupancy), 64'(0));

        // Short non-final line followed by an empty packet
        tb_tog = ~tb_tog;
        send_pkt(tb_tog, 3, 1'b0, 32'h400, 1'b1);
        tb_tog = ~tb_tog;
        send_pkt(tb_tog, 0, 1'b1, 32'h500, 1'b1);
        chk("t3_zero_occ", 64'(bus.occupancy), 64'(1));
        for (int i = 0; i < 3; i++) begin
            chk("t3_valid", 64'(bus.o_valid), 64'(1));
            chk("t3_last", 64'(bus.o_last), 64'(0));
            tick();
        end
        drain("t3_queue");

        // Downstream stall in mid-line
        tb_tog = ~tb_tog;
        send_pkt(tb_tog, 7, 1'b1, 32'h600, 1'b1);
        tick();
        tick();
        tick();
        chk("t4_pre_out", 64'(bus.OUT), 64'h633);
        bus.i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_out", 64'(bus.OUT), 64'h633);
            chk("t4_hold_valid", 64'(bus.o_valid), 64'(1));
            chk("t4_hold_last", 64'(bus.o_last), 64'(0));
            chk("t4_hold_occ", 64'(bus.occupancy), 64'(1));
        end
        bus.i_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_resume_valid", 64'(bus.o_valid), 64'(1));
            tick();
        end
        chk("t4_end_valid", 64'(bus.o_valid), 64'(0));
        chk("t4_queue", 64'(exp_q.size()), 64'(0));

        // Duplicate toggle handling
        t = ~tb_tog;
        send_pkt(t, 2, 1'b1, 32'h700, 1'b1);
`ifdef LIST_STREAM_CACHE_DUP_DROP_EN
        send_pkt(t, 2, 1'b1, 32'h800, 1'b0);
`else
        send_pkt(t, 2, 1'b1, 32'h800, 1'b1);
`endif
        send_pkt(~t, 2, 1'b1, 32'h900, 1'b1);
        tb_tog = ~t;
        drain("t5_queue");

        // Flush with two lines held and a line in progress
        tb_tog = ~tb_tog;
        send_pkt(tb_tog, 7, 1'b1, 32'hA00, 1'b1);
        tb_tog = ~tb_tog;
        send_pkt(tb_tog, 7, 1'b1, 32'hB00, 1'b1);
        tick();
        chk("t6_pre_occ", 64'(bus.occupancy), 64'(2));
        bus.flush    = 1'b1;
        bus.IN       = mk_pkt(~tb_tog, 2, 1'b1, 32'hC00);
        bus.in_valid = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        chk("t6_ovalid", 64'(bus.o_valid), 64'(0));
        chk("t6_olast", 64'(bus.o_last), 64'(0));
        chk("t6_occ", 64'(bus.occupancy), 64'(0));
        chk("t6_ready", 64'(bus.in_ready), 64'(1));
        tick();
        tick();
        chk("t6_no_accept_valid", 64'(bus.o_valid), 64'(0));
        chk("t6_no_accept_occ", 64'(bus.occupancy), 64'(0));
        tb_tog = ~tb_tog;
        send_pkt(tb_tog, 2, 1'b1, 32'hD00, 1'b1);
        tick();
        chk("t6_new_first", 64'(bus.OUT), 64'hD11);
        drain("t6_queue");

        // Asynchronous reset in mid-stream
        tb_tog = ~tb_tog;
        send_pkt(tb_tog, 7, 1'b1, 32'hE00, 1'b1);
        tick();
        tick();
        RESET_N = 1'b0;
        #1;
        chk("t7_ovalid", 64'(bus.o_valid), 64'(0));
        chk("t7_occ", 64'(bus.occupancy), 64'(0));
        chk("t7_out", 64'(bus.OUT), 64'(0));
        chk("t7_olast", 64'(bus.o_last), 64'(0));
        exp_q.delete();
        tb_tog = 1'b1;
        @(negedge CLK);
        RESET_N = 1'b1;
        tb_tog = ~tb_tog;
        send_pkt(tb_tog, 3, 1'b1, 32'hF00, 1'b1);
        tick();
        chk("t7_new_first", 64'(bus.OUT), 64'hF11);
        drain("t7_queue");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
